// File: rtl/collision_map_arbiter.sv
// -----------------------------------------------------------------------------
// collision_map_arbiter
//
// Shares one single-port level-map ROM between the fire (requester 0) and
// water (requester 1) movement controllers. Each requester issues a pixel
// (x, y) solidity lookup over valid/ready. One lookup is accepted per cycle.
// The accepted pixel is converted to a tile address that is registered onto
// rom_addr. A tag pipeline follows the ROM latency, and a one-cycle response
// pulse goes back to the requester that issued the lookup, in grant order.
// Pixels outside the map still use a slot. They drive address 0 and always
// report solid.
//
// Configuration:
//   ARB_FIXED_PRIO_EN (macro) - when defined, requester 0 always wins a tie
//                               and the round-robin pointer does not exist.
//                               When undefined, arbitration is round-robin.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req0_valid/x/y, req0_ready   requester 0 (fire) lookup handshake
//   resp0_valid, resp0_solid     requester 0 response (one-cycle pulse)
//   req1_* / resp1_*             same as above for requester 1 (water)
//   rom_addr                     tile address to the map ROM
//   rom_data                     tile solidity, ROM_LAT clocks after rom_addr
// -----------------------------------------------------------------------------
module collision_map_arbiter #(
    parameter int MAP_W_PX   = 1024,
    parameter int MAP_H_PX   = 768,
    parameter int TILE_SHIFT = 5,
    parameter int ROM_LAT    = 1,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [11:0]       req0_x,
    input  logic [11:0]       req0_y,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic              resp0_solid,
    input  logic              req1_valid,
    input  logic [11:0]       req1_x,
    input  logic [11:0]       req1_y,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic              resp1_solid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data
);
    localparam int COLS = MAP_W_PX >> TILE_SHIFT;

    // Each tag records one accepted lookup as it moves down the pipeline.
    typedef struct packed {
        logic valid;
        logic id;
        logic oob;
    } tag_t;

    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [11:0]       sel_x;
    logic [11:0]       sel_y;
    logic [11:0]       tile_x;
    logic [11:0]       tile_y;
    logic              sel_oob;
    logic [ADDR_W-1:0] tile_addr;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`else
    // last_grant_reg holds the requester granted most recently. On a tie,
    // the other requester wins. The reset value of 1 makes requester 0 win
    // the first tie.
    logic last_grant_reg;

    assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (xfer) begin
            last_grant_reg <= grant1;
        end
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;

    // ------------------------------------------------------------------
    // Pixel to tile address for the requester that wins this cycle
    // ------------------------------------------------------------------
    assign sel_x     = grant1 ? req1_x : req0_x;
    assign sel_y     = grant1 ? req1_y : req0_y;
    assign sel_oob   = (32'(sel_x) >= MAP_W_PX) || (32'(sel_y) >= MAP_H_PX);
    assign tile_x    = sel_x >> TILE_SHIFT;
    assign tile_y    = sel_y >> TILE_SHIFT;
    assign tile_addr = ADDR_W'(tile_y) * ADDR_W'(COLS) + ADDR_W'(tile_x);

    // rom_addr changes only on an accepted lookup. It holds its value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else if (xfer) begin
            rom_addr <= sel_oob ? '0 : tile_addr;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline
    // Stage k is loaded k+1 edges after acceptance. Stage ROM_LAT therefore
    // lines up with the rom_data returned for that lookup.
    // ------------------------------------------------------------------
    tag_t tag_reg [0:ROM_LAT];
    tag_t tag_d   [0:ROM_LAT];
    tag_t tag_out;

    assign tag_d[0] = {xfer, grant1, sel_oob};

    genvar gi;
    generate
        for (gi = 0; gi <= ROM_LAT; gi++) begin : g_tag
            if (gi > 0) begin : g_link
                assign tag_d[gi] = tag_reg[gi-1];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_reg[gi] <= '0;
                end else begin
                    tag_reg[gi] <= tag_d[gi];
                end
            end
        end
    endgenerate

    assign tag_out = tag_reg[ROM_LAT];

    // ------------------------------------------------------------------
    // Response registers
    // Each solid flag keeps its last value between pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            resp0_valid <= 1'b0;
            resp0_solid <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_solid <= 1'b0;
        end else begin
            resp0_valid <= tag_out.valid && !tag_out.id;
            resp1_valid <= tag_out.valid && tag_out.id;
            if (tag_out.valid && !tag_out.id) begin
                resp0_solid <= tag_out.oob | rom_data;
            end
            if (tag_out.valid && tag_out.id) begin
                resp1_solid <= tag_out.oob | rom_data;
            end
        end
    end

endmodule

// File: tb/tb_collision_map_arbiter.sv
// -----------------------------------------------------------------------------
// tb_collision_map_arbiter
//
// Two instances of the arbiter receive identical request stimulus. One has
// ROM_LAT=1 and the other has ROM_LAT=3. Each instance has its own ROM model
// built from a shared random map image. The directed scenarios check
// hand-derived addresses, grant order and response timing. The random
// scenario checks both instances against an abstract model: it computes the
// grant from the rules, computes the tile index by division, and schedules
// each response on a timeline indexed by cycle.
// -----------------------------------------------------------------------------
module tb_collision_map_arbiter;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin  [2];
    logic [11:0] xin  [2];
    logic [11:0] yin  [2];
    logic        rdy  [2][2];
    logic        rv   [2][2];
    logic        rs   [2][2];
    logic [AW-1:0] addr [2];
    logic        rdata [2];

    int checks = 0;
    int errors = 0;
    int lat [2] = '{1, 3};

    bit       rom_mem [0:1023];
    logic [2:0] pipe_a;
    logic [2:0] pipe_b;

    always #5 clk = ~clk;

    collision_map_arbiter #(.ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(vin[0]), .req0_x(xin[0]), .req0_y(yin[0]), .req0_ready(rdy[0][0]),
        .resp0_valid(rv[0][0]), .resp0_solid(rs[0][0]),
        .req1_valid(vin[1]), .req1_x(xin[1]), .req1_y(yin[1]), .req1_ready(rdy[0][1]),
        .resp1_valid(rv[0][1]), .resp1_solid(rs[0][1]),
        .rom_addr(addr[0]), .rom_data(rdata[0])
    );

    collision_map_arbiter #(.ROM_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(vin[0]), .req0_x(xin[0]), .req0_y(yin[0]), .req0_ready(rdy[1][0]),
        .resp0_valid(rv[1][0]), .resp0_solid(rs[1][0]),
        .req1_valid(vin[1]), .req1_x(xin[1]), .req1_y(yin[1]), .req1_ready(rdy[1][1]),
        .resp1_valid(rv[1][1]), .resp1_solid(rs[1][1]),
        .rom_addr(addr[1]), .rom_data(rdata[1])
    );

    // ROM models with one and three clocks of read latency.
    always @(posedge clk) begin
        pipe_a <= {pipe_a[1:0], rom_mem[addr[0]]};
        pipe_b <= {pipe_b[1:0], rom_mem[addr[1]]};
    end
    assign rdata[0] = pipe_a[0];
    assign rdata[1] = pipe_b[2];

    // ------------------------------------------------------------------
    // Abstract reference model state, used by the random scenario
    // ------------------------------------------------------------------
    bit            ptr;          // requester granted most recently
    int            cyc;
    logic [AW-1:0] exp_addr;
    logic [1:0]    last_g;
    bit            ev [2][2][0:511];
    bit            es [2][2][0:511];

    int seq_port [16];
    int seq_x    [16];
    int seq_y    [16];

    function automatic logic [1:0] ref_grant(input logic a, input logic b);
`ifdef ARB_FIXED_PRIO_EN
        if (a) return 2'b01;
        if (b) return 2'b10;
        return 2'b00;
`else
        if (a && b) return ptr ? 2'b01 : 2'b10;
        if (a) return 2'b01;
        if (b) return 2'b10;
        return 2'b00;
`endif
    endfunction

    // Advances one clock and applies the rules to the inputs sampled at this edge.
    task automatic tick();
        int p;
        int a;
        bit oob;
        @(posedge clk);
        cyc++;
        last_g = 2'b00;
        if (rst) begin
            ptr = 1'b1;
            exp_addr = '0;
            for (int d = 0; d < 2; d++)
                for (int q = 0; q < 2; q++)
                    for (int k = 0; k < 5; k++) ev[d][q][cyc+k] = 1'b0;
        end else begin
            last_g = ref_grant(vin[0], vin[1]);
            if (last_g != 2'b00) begin
                p = last_g[1] ? 1 : 0;
                oob = (xin[p] >= 1024) || (yin[p] >= 768);
                a = oob ? 0 : (int'(yin[p]) / 32) * (1024 / 32) + int'(xin[p]) / 32;
                exp_addr = AW'(a);
                ptr = (p == 1);
                for (int d = 0; d < 2; d++) begin
                    ev[d][p][cyc+lat[d]+1] = 1'b1;
                    es[d][p][cyc+lat[d]+1] = oob | rom_mem[a];
                end
            end
        end
        #1;
    endtask

    task automatic set_idle();
        for (int p = 0; p < 2; p++) begin
            vin[p] = 1'b0;
            xin[p] = '0;
            yin[p] = '0;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (addr[d] !== '0) begin
                errors++;
                $display("FAIL reset_addr dut%0d got %0d expected 0", d, addr[d]);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({rdy[d][p], rv[d][p], rs[d][p]} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d port%0d got rdy/rv/rs=%b%b%b expected 000",
                             d, p, rdy[d][p], rv[d][p], rs[d][p]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs a table of n lookups with exactly one acceptance per cycle, in
    // table order. In contention mode, both requesters stay valid and present
    // their next pending lookup.
    task automatic run_burst(input string name, input int n, input bit both);
        int  ea [16];
        bit  eso [16];
        bit  oob;
        int  nxt;
        int  j;
        bit  exp_v;
        for (int i = 0; i < n; i++) begin
            oob = (seq_x[i] >= 1024) || (seq_y[i] >= 768);
            ea[i] = oob ? 0 : (seq_y[i] / 32) * 32 + seq_x[i] / 32;
            eso[i] = oob ? 1'b1 : rom_mem[ea[i]];
        end
        for (int t = 0; t < n + 5; t++) begin
            @(negedge clk);
            set_idle();
            if (t < n) begin
                for (int p = 0; p < 2; p++) begin
                    nxt = -1;
                    for (int i = n - 1; i >= t; i--) if (seq_port[i] == p) nxt = i;
                    if (both || seq_port[t] == p) begin
                        vin[p] = 1'b1;
                        xin[p] = (nxt >= 0) ? 12'(seq_x[nxt]) : 12'd0;
                        yin[p] = (nxt >= 0) ? 12'(seq_y[nxt]) : 12'd0;
                    end
                end
                #1;
                for (int d = 0; d < 2; d++)
                    for (int p = 0; p < 2; p++) begin
                        checks++;
                        if (rdy[d][p] !== (seq_port[t] == p)) begin
                            errors++;
                            $display("FAIL %s_ready dut%0d port%0d cycle%0d got %b expected %b",
                                     name, d, p, t, rdy[d][p], (seq_port[t] == p));
                        end
                    end
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (t < n) begin
                    checks++;
                    if (addr[d] !== AW'(ea[t])) begin
                        errors++;
                        $display("FAIL %s_addr dut%0d cycle%0d got %0d expected %0d",
                                 name, d, t, addr[d], ea[t]);
                    end
                end
                j = t - lat[d] - 1;
                for (int p = 0; p < 2; p++) begin
                    exp_v = (j >= 0) && (j < n) && (seq_port[j] == p);
                    checks++;
                    if (rv[d][p] !== exp_v) begin
                        errors++;
                        $display("FAIL %s_resp_valid dut%0d port%0d cycle%0d got %b expected %b",
                                 name, d, p, t, rv[d][p], exp_v);
                    end
                    if (exp_v) begin
                        checks++;
                        if (rs[d][p] !== eso[j]) begin
                            errors++;
                            $display("FAIL %s_resp_solid dut%0d port%0d lookup%0d got %b expected %b",
                                     name, d, p, j, rs[d][p], eso[j]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        seq_port[0] = 0; seq_x[0] = 40; seq_y[0] = 70;   // tile (1,2) -> address 65
        run_burst("single", 1, 1'b0);
    endtask

    task automatic test_contention();
        pulse_reset(1);
        for (int t = 0; t < 6; t++) begin
            seq_port[t] = t % 2;
            seq_x[t] = (t % 2 == 0) ? (t / 2) * 32 + 5 : 700;
            seq_y[t] = (t % 2 == 0) ? 64 : (t / 2) * 32;
        end
        run_burst("contention", 6, 1'b1);
    endtask

    task automatic test_out_of_range();
        seq_port[0] = 1; seq_x[0] = 1024; seq_y[0] = 10;
        seq_port[1] = 1; seq_x[1] = 1023; seq_y[1] = 767;
        seq_port[2] = 1; seq_x[2] = 5;    seq_y[2] = 768;
        seq_port[3] = 0; seq_x[3] = 4095; seq_y[3] = 4095;
        run_burst("oob", 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            seq_port[i] = 0;
            seq_x[i] = i * 32 + 3;
            seq_y[i] = i * 32 + 7;
        end
        run_burst("b2b", 8, 1'b0);
    endtask

    task automatic test_reset_midflight();
        // A lone requester-0 lookup leaves requester 0 as the last grant.
        @(negedge clk);
        set_idle();
        vin[0] = 1'b1; xin[0] = 12'd40; yin[0] = 12'd70;
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rv[d][0] !== 1'b0 || rv[d][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL midflight_no_resp dut%0d cycle%0d got %b%b expected 00",
                             d, t, rv[d][1], rv[d][0]);
                end
            end
        end
        @(negedge clk);
        vin[0] = 1'b1; xin[0] = 12'd1; yin[0] = 12'd1;
        vin[1] = 1'b1; xin[1] = 12'd2; yin[1] = 12'd2;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d][0] !== 1'b1 || rdy[d][1] !== 1'b0) begin
                errors++;
                $display("FAIL midflight_tie dut%0d got ready1/0=%b%b expected 01",
                         d, rdy[d][1], rdy[d][0]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        bit held [2];
        logic [1:0] g;
        pulse_reset(2);
        ptr = 1'b1;
        exp_addr = '0;
        cyc = 0;
        last_g = 2'b00;
        held[0] = 1'b0;
        held[1] = 1'b0;
        for (int t = 0; t < 305; t++) begin
            @(negedge clk);
            if (t >= 300) begin
                rst = 1'b0;
                set_idle();
            end else begin
                rst = ($urandom_range(0, 59) == 0);
                for (int p = 0; p < 2; p++) begin
                    if (!held[p]) begin
                        vin[p] = ($urandom_range(0, 2) != 0);
                        xin[p] = 12'($urandom_range(0, 1100));
                        yin[p] = 12'($urandom_range(0, 820));
                    end
                end
            end
            #1;
            if (!rst) begin
                g = ref_grant(vin[0], vin[1]);
                for (int d = 0; d < 2; d++)
                    for (int p = 0; p < 2; p++) begin
                        checks++;
                        if (rdy[d][p] !== g[p]) begin
                            errors++;
                            $display("FAIL rand_ready dut%0d port%0d cycle%0d got %b expected %b",
                                     d, p, t, rdy[d][p], g[p]);
                        end
                    end
            end
            tick();
            for (int p = 0; p < 2; p++) held[p] = vin[p] && !last_g[p];
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (addr[d] !== exp_addr) begin
                    errors++;
                    $display("FAIL rand_addr dut%0d cycle%0d got %0d expected %0d",
                             d, t, addr[d], exp_addr);
                end
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (rv[d][p] !== ev[d][p][cyc]) begin
                        errors++;
                        $display("FAIL rand_resp_valid dut%0d port%0d cycle%0d got %b expected %b",
                                 d, p, t, rv[d][p], ev[d][p][cyc]);
                    end
                    if (ev[d][p][cyc]) begin
                        checks++;
                        if (rs[d][p] !== es[d][p][cyc]) begin
                            errors++;
                            $display("FAIL rand_resp_solid dut%0d port%0d cycle%0d got %b expected %b",
                                     d, p, t, rs[d][p], es[d][p][cyc]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom_range(0, 1));
        rom_mem[0] = 1'b0;   // out-of-range lookups must report solid even though address 0 is clear
        test_reset();
        test_single();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
